// File: rtl/bus_arbiter.sv
// Two-port Avalon-MM bus arbiter: fair tie-break between fetch (port 0) and data (port 1),
// one transfer in flight, optional waitrequest timeout that completes the transfer with an error.
module bus_arbiter #(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_write,
    input  logic        p1_write,
    input  logic [31:0] p0_address,
    input  logic [31:0] p1_address,
    input  logic [31:0] p0_writedata,
    input  logic [31:0] p1_writedata,
    input  logic [3:0]  p0_byteenable,
    input  logic [3:0]  p1_byteenable,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic        p0_error,
    output logic        p1_error,
    output logic [31:0] p0_readdata,
    output logic [31:0] p1_readdata,
    output logic [31:0] address,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic {IDLE, ACCESS} state_t;

    // The abort fires on the stall edge that brings the counter up to WAIT_LIMIT.
    localparam logic [31:0] LIMIT_M1 = (WAIT_LIMIT == 0) ? 32'd0 : 32'(WAIT_LIMIT - 1);

    state_t      state, state_next;
    logic        owner;
    logic        last_grant;
    logic        lat_write;
    logic [31:0] stall_cnt;

    logic        p0_elig, p1_elig;
    logic        winner;
    logic        start, done, timeout;

    assign p0_elig = p0_req & ~p0_ack;
    assign p1_elig = p1_req & ~p1_ack;

    // Last_grant holds the index of the port served last, so a tie goes to the other one.
    always_comb begin
        winner = 1'b0;
        if (p0_elig && p1_elig)
            winner = ~last_grant;
        else if (p1_elig)
            winner = 1'b1;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (p0_elig || p1_elig) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!waitrequest) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (WAIT_LIMIT != 0 && stall_cnt >= LIMIT_M1) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign read  = (state == ACCESS) && !lat_write;
    assign write = (state == ACCESS) &&  lat_write;
    assign grant = (state == ACCESS) ? {owner, ~owner} : 2'b00;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            lat_write   <= 1'b0;
            address     <= '0;
            writedata   <= '0;
            byteenable  <= '0;
            stall_cnt   <= '0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_error    <= 1'b0;
            p1_error    <= 1'b0;
            p0_readdata <= '0;
            p1_readdata <= '0;
        end else begin
            state    <= state_next;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_error <= 1'b0;
            p1_error <= 1'b0;

            if (start) begin
                owner      <= winner;
                last_grant <= winner;
                lat_write  <= winner ? p1_write      : p0_write;
                address    <= winner ? p1_address    : p0_address;
                writedata  <= winner ? p1_writedata  : p0_writedata;
                byteenable <= winner ? p1_byteenable : p0_byteenable;
                stall_cnt  <= '0;
            end else if (state == ACCESS && waitrequest && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end

            if (done) begin
                if (owner) begin
                    p1_ack <= 1'b1;
                    if (!lat_write) p1_readdata <= readdata;
                end else begin
                    p0_ack <= 1'b1;
                    if (!lat_write) p0_readdata <= readdata;
                end
            end

            if (timeout) begin
                if (owner) begin
                    p1_ack      <= 1'b1;
                    p1_error    <= 1'b1;
                    p1_readdata <= '0;
                end else begin
                    p0_ack      <= 1'b1;
                    p0_error    <= 1'b1;
                    p0_readdata <= '0;
                end
            end
        end
    end

endmodule
